bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, binary input width (legal range 4..32).
REQ-002 The block SHALL have parameter DIGITS, default 5, number of BCD output digits (legal range 1..10).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  conversion request, sampled on the rising edge of clk.
REQ-006 The block SHALL have port x  input  WIDTH  value to convert, sampled with start.
REQ-007 The block SHALL have port signed_mode  input  1  when 1, x is two's complement; sampled with start.
REQ-008 The block SHALL have port busy  output  1  high while a conversion is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-010 The block SHALL have port bcd  output  4*DIGITS  BCD result, digit k at bits [4k+3:4k], digit 0 = units.
REQ-011 The block SHALL have port neg  output  1  result sign; 1 = negative.
REQ-012 The block SHALL have port overflow  output  1  magnitude did not fit in DIGITS digits.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CONV and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL capture x and signed_mode, clear the digit register, clear the shift count, and go to CONV; start is ignored in CONV.
REQ-015 At capture, if signed_mode=1 and x[WIDTH-1]=1, the magnitude SHALL be the WIDTH-bit two's-complement negation of x and the internal sign SHALL be 1; otherwise the magnitude is x and the sign is 0.
REQ-016 The signed minimum 2^(WIDTH-1) SHALL convert as unsigned magnitude 2^(WIDTH-1) with sign 1.
REQ-017 Each CONV cycle SHALL perform one double-dabble step: for every digit >= 5, add 3 (4-bit), then shift the {digits, magnitude} register left by one bit.
REQ-018 A 1 shifted out of the top digit during any step SHALL set a sticky overflow bit for that conversion.
REQ-019 After exactly WIDTH CONV cycles the FSM SHALL enter DONE, and bcd, neg and overflow SHALL be registered on that same edge.
REQ-020 When overflow is set, bcd SHALL saturate to all digits = 9.
REQ-021 done SHALL be 1 only in DONE, and DONE SHALL last exactly one cycle: to CONV if start=1, else to IDLE.
REQ-022 busy SHALL equal 1 exactly while in CONV.
REQ-023 Latency SHALL be WIDTH+1 cycles from the start-sampling edge to the done cycle; back-to-back throughput SHALL be one conversion per WIDTH+1 cycles.
REQ-024 bcd, neg and overflow SHALL hold their last values from DONE until the next DONE and SHALL NOT change during CONV.
REQ-025 neg SHALL be 0 whenever the converted magnitude is zero.
REQ-026 Changes on x and signed_mode outside the start-sampling edge SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately, regardless of clk, force state IDLE, busy=0, done=0, bcd=0, neg=0, overflow=0, and clear all internal registers.
REQ-028 Reset asserted during CONV SHALL abort the conversion with no done pulse.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-030 WIDTH=16, DIGITS=5, signed_mode=0, x=16'hFFFF -> after 17 cycles: done pulse, bcd=20'h65535, neg=0, overflow=0; busy high for 16 cycles.
REQ-031 WIDTH=16, DIGITS=5, signed_mode=1, x=16'hFFFF -> bcd=20'h00001, neg=1; x=16'h8000 -> bcd=20'h32768, neg=1; x=0 -> bcd=0, neg=0.
REQ-032 WIDTH=8, DIGITS=2, x=8'd255 -> overflow=1, bcd=8'h99; then x=8'd99 -> overflow=0, bcd=8'h99.
REQ-033 start held high with x=1234, then 4321 -> done pulses exactly 17 cycles apart, results 01234 then 04321; a start pulse during CONV -> ignored.
REQ-034 rst_n pulsed low mid-CONV -> outputs immediately 0, no done pulse; the next start converts correctly.
REQ-035 Sweep WIDTH=10, DIGITS=4 over all x in both modes -> bcd, neg and overflow match a decimal reference model.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The requester drives start/x/signed_mode; the converter returns status and result.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      x;
  logic                  signed_mode;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  overflow;

  modport master (
    output start, x, signed_mode,
    input  busy, done, bcd, neg, overflow
  );

  modport slave (
    input  start, x, signed_mode,
    output busy, done, bcd, neg, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, WIDTH steps per conversion,
// optional two's-complement input, sticky overflow with all-nines saturation.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state_reg, state_next;
  logic [BW-1:0]   digits_reg;
  logic [BW-1:0]   digits_adj;
  logic [BW-1:0]   digits_step;
  logic [WIDTH-1:0] mag_reg;
  logic [WIDTH-1:0] mag_step;
  logic [WIDTH-1:0] x_abs;
  logic [CW-1:0]   cnt_reg;
  logic            sign_reg;
  logic            ovf_reg;
  logic            ovf_step;
  logic            x_neg;
  logic            capture;
  logic            last_step;
  logic [BW-1:0]   bcd_reg;
  logic            neg_reg;
  logic            overflow_reg;

  // Add-3 correction on every digit that would exceed 9 after doubling.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign digits_adj[4*gi +: 4] = (digits_reg[4*gi +: 4] >= 4'd5)
                                   ? digits_reg[4*gi +: 4] + 4'd3
                                   : digits_reg[4*gi +: 4];
    end
  endgenerate

  assign digits_step = {digits_adj[BW-2:0], mag_reg[WIDTH-1]};
  assign mag_step    = {mag_reg[WIDTH-2:0], 1'b0};
  assign ovf_step    = ovf_reg | digits_adj[BW-1];
  assign last_step   = (cnt_reg == LAST_STEP);

  // Negating the signed minimum wraps back to itself, which is the correct magnitude.
  assign x_neg = bus.signed_mode & bus.x[WIDTH-1];
  assign x_abs = x_neg ? (~bus.x + 1'b1) : bus.x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          capture    = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        capture    = bus.start;
        state_next = bus.start ? CONV : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_reg   <= '0;
      mag_reg      <= '0;
      cnt_reg      <= '0;
      sign_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      bcd_reg      <= '0;
      neg_reg      <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (capture) begin
      digits_reg <= '0;
      mag_reg    <= x_abs;
      sign_reg   <= x_neg;
      cnt_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else if (state_reg == CONV) begin
      digits_reg <= digits_step;
      mag_reg    <= mag_step;
      ovf_reg    <= ovf_step;
      cnt_reg    <= cnt_reg + 1'b1;
      // Results are published only on the edge that completes the final step.
      if (last_step) begin
        bcd_reg      <= ovf_step ? ALL_NINES : digits_step;
        neg_reg      <= sign_reg & (ovf_step | (|digits_step));
        overflow_reg <= ovf_step;
      end
    end
  end

  assign bus.busy     = (state_reg == CONV);
  assign bus.done     = (state_reg == DONE);
  assign bus.bcd      = bcd_reg;
  assign bus.neg      = neg_reg;
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three parameterisations share one clock and are checked against
// a decimal reference model built from plain integer arithmetic.
module tb_bin2bcd_seq;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [19:0] prev16_bcd;

  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) b16 ();
  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) b8 ();
  bin2bcd_seq_if #(.WIDTH(10), .DIGITS(4)) b10 ();

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  bin2bcd_seq #(.WIDTH(8),  .DIGITS(2)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) u10 (.clk(clk), .rst_n(rst_n), .bus(b10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    bit          sm;
    logic [19:0] bcd;
    bit          neg;
    bit          ovf;
  } vec_t;

  vec_t tbl[9];

  // Decimal reference: magnitude, sign, saturation from arithmetic only.
  function automatic void model(input logic [31:0] xv, input int w, input int d, input bit sm,
                                output logic [63:0] bcd, output bit neg, output bit ovf);
    longint unsigned mag, lim, t;
    mag = 64'(xv) & ((64'd1 << w) - 64'd1);
    neg = 1'b0;
    if (sm && xv[w-1]) begin
      mag = (64'd1 << w) - mag;
      neg = 1'b1;
    end
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    ovf = (mag >= lim);
    bcd = '0;
    t   = mag;
    for (int i = 0; i < d; i++) begin
      if (ovf) bcd[4*i +: 4] = 4'h9;
      else begin
        bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic conv16(input logic [15:0] xv, input bit sm, input logic [19:0] eb,
                        input bit en, input bit eo, input string nm);
    int k, busy_n;
    bit seen, hold_ok;
    @(negedge clk);
    b16.x = xv; b16.signed_mode = sm; b16.start = 1'b1;
    @(posedge clk); #1;
    b16.start = 1'b0; b16.x = 16'($urandom); b16.signed_mode = ~sm;
    k = 0; busy_n = 0; seen = 0; hold_ok = 1;
    while (!seen && k < 40) begin
      if (b16.done) seen = 1;
      else begin
        if (b16.busy) busy_n++;
        if (b16.bcd !== prev16_bcd) hold_ok = 0;
        @(posedge clk); #1;
        k++;
      end
    end
    chk({nm, " latency"}, 64'(k), 64'd16);
    chk({nm, " busy_cycles"}, 64'(busy_n), 64'd16);
    chk({nm, " hold_during_conv"}, 64'(hold_ok), 64'd1);
    chk({nm, " bcd"}, 64'(b16.bcd), 64'(eb));
    chk({nm, " neg"}, 64'(b16.neg), 64'(en));
    chk({nm, " ovf"}, 64'(b16.overflow), 64'(eo));
    $display("conv16 %s x=%h sm=%0d -> bcd=%h neg=%0d ovf=%0d", nm, xv, sm, b16.bcd, b16.neg, b16.overflow);
    prev16_bcd = eb;
  endtask

  task automatic conv8(input logic [7:0] xv, input bit sm, input string nm);
    logic [63:0] eb; bit en, eo; int k;
    model(32'(xv), 8, 2, sm, eb, en, eo);
    @(negedge clk);
    b8.x = xv; b8.signed_mode = sm; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    k = 0;
    while (!b8.done && k < 30) begin @(posedge clk); #1; k++; end
    chk({nm, " done"}, 64'(b8.done), 64'd1);
    chk({nm, " bcd"}, 64'(b8.bcd), eb);
    chk({nm, " neg"}, 64'(b8.neg), 64'(en));
    chk({nm, " ovf"}, 64'(b8.overflow), 64'(eo));
    $display("conv8 %s x=%h sm=%0d -> bcd=%h neg=%0d ovf=%0d", nm, xv, sm, b8.bcd, b8.neg, b8.overflow);
  endtask

  task automatic conv10(input logic [9:0] xv, input bit sm);
    logic [63:0] eb; bit en, eo; int k;
    model(32'(xv), 10, 4, sm, eb, en, eo);
    @(negedge clk);
    b10.x = xv; b10.signed_mode = sm; b10.start = 1'b1;
    @(posedge clk); #1;
    b10.start = 1'b0;
    k = 0;
    while (!b10.done && k < 30) begin @(posedge clk); #1; k++; end
    chk("w10 done", 64'(b10.done), 64'd1);
    chk("w10 bcd", 64'(b10.bcd), eb);
    chk("w10 neg", 64'(b10.neg), 64'(en));
    chk("w10 ovf", 64'(b10.overflow), 64'(eo));
    $display("conv10 x=%h sm=%0d -> bcd=%h neg=%0d ovf=%0d", xv, sm, b10.bcd, b10.neg, b10.overflow);
  endtask

  initial begin
    logic [63:0] eb; bit en, eo;
    int k, d1, d2, ndone;

    tbl[0] = '{16'hFFFF, 1'b0, 20'h65535, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 1'b1, 20'h00001, 1'b1, 1'b0};
    tbl[2] = '{16'h8000, 1'b1, 20'h32768, 1'b1, 1'b0};
    tbl[3] = '{16'h0000, 1'b1, 20'h00000, 1'b0, 1'b0};
    tbl[4] = '{16'd1234, 1'b0, 20'h01234, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 1'b0, 20'h32768, 1'b0, 1'b0};
    tbl[6] = '{16'h7FFF, 1'b1, 20'h32767, 1'b0, 1'b0};
    tbl[7] = '{16'hFFF6, 1'b1, 20'h00010, 1'b1, 1'b0};
    tbl[8] = '{16'd9,    1'b0, 20'h00009, 1'b0, 1'b0};

    n_cmp = 0; n_bad = 0; prev16_bcd = '0;
    rst_n = 1'b0;
    b16.start = 0; b16.x = '0; b16.signed_mode = 0;
    b8.start  = 0; b8.x  = '0; b8.signed_mode  = 0;
    b10.start = 0; b10.x = '0; b10.signed_mode = 0;
    // Junk on the request lines during reset must not start anything.
    b16.start = 1; b16.x = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    chk("reset w16 outputs", 64'({b16.busy, b16.done, b16.neg, b16.overflow, b16.bcd}), 64'd0);
    chk("reset w8 outputs", 64'({b8.busy, b8.done, b8.neg, b8.overflow, b8.bcd}), 64'd0);
    chk("reset w10 outputs", 64'({b10.busy, b10.done, b10.neg, b10.overflow, b10.bcd}), 64'd0);
    b16.start = 0;
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      conv16(tbl[i].x, tbl[i].sm, tbl[i].bcd, tbl[i].neg, tbl[i].ovf, $sformatf("vec%0d", i));

    // Back-to-back with start held high: done pulses WIDTH+1 apart.
    @(negedge clk);
    b16.x = 16'd1234; b16.signed_mode = 0; b16.start = 1;
    @(posedge clk); #1;
    b16.x = 16'd4321;
    k = 0; d1 = -1; d2 = -1;
    while (k < 60 && d2 < 0) begin
      if (b16.done) begin
        if (d1 < 0) begin d1 = k; chk("b2b first bcd", 64'(b16.bcd), 64'h01234); end
        else begin d2 = k; chk("b2b second bcd", 64'(b16.bcd), 64'h04321); end
      end
      if (d1 >= 0 && k == d1 + 1) b16.start = 0;
      @(posedge clk); #1;
      k++;
    end
    b16.start = 0;
    chk("b2b done spacing", 64'(d2 - d1), 64'd17);
    $display("b2b done at %0d and %0d", d1, d2);
    prev16_bcd = 20'h04321;

    // A start pulse in the middle of a conversion is ignored.
    @(negedge clk);
    b16.x = 16'd777; b16.signed_mode = 0; b16.start = 1;
    @(posedge clk); #1;
    b16.start = 0; b16.x = 16'd999;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) b16.start = 1;
      if (c == 6) b16.start = 0;
      if (b16.done) begin
        ndone++;
        if (ndone == 1) begin
          chk("ignored-start bcd", 64'(b16.bcd), 64'h00777);
          chk("ignored-start latency", 64'(c), 64'd16);
        end
      end
      @(posedge clk); #1;
    end
    chk("ignored-start done count", 64'(ndone), 64'd1);
    $display("ignored-start done pulses=%0d", ndone);

    // Reset in the middle of a conversion: immediate clear, no done.
    @(negedge clk);
    b16.x = 16'd4321; b16.signed_mode = 0; b16.start = 1;
    @(posedge clk); #1;
    b16.start = 0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid-conv reset outputs", 64'({b16.busy, b16.done, b16.neg, b16.overflow, b16.bcd}), 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (b16.done) ndone++;
    end
    chk("mid-conv reset no done", 64'(ndone), 64'd0);
    $display("mid-conv reset done pulses=%0d", ndone);
    prev16_bcd = '0;
    conv16(16'd9876, 1'b0, 20'h09876, 1'b0, 1'b0, "after-reset");

    for (int i = 0; i < 150; i++) begin
      logic [15:0] rx; bit rs;
      rx = 16'($urandom); rs = 1'($urandom);
      model(32'(rx), 16, 5, rs, eb, en, eo);
      conv16(rx, rs, eb[19:0], en, eo, "rand16");
    end

    conv8(8'd255, 1'b0, "w8 255");
    chk("w8 255 saturate", 64'({b8.overflow, b8.bcd}), 64'h199);
    conv8(8'd99, 1'b0, "w8 99");
    chk("w8 99 exact", 64'({b8.overflow, b8.bcd}), 64'h099);
    conv8(8'd100, 1'b0, "w8 100");
    conv8(8'h80, 1'b1, "w8 -128");
    for (int i = 0; i < 100; i++) conv8(8'($urandom), 1'($urandom), "rand8");

    for (int s = 0; s < 2; s++)
      for (int v = 0; v < 1024; v++)
        conv10(10'(v), 1'(s));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
